// File: rtl/rd_ptr_empty_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : rd_ptr_empty_gen_if
// Description : Read-side FIFO pointer/status bundle between the consumer
//               (master) and the read pointer/empty generator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rd_ptr_empty_gen_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  r_inc;
    logic [ADDR_WIDTH:0]   w_ptr_sync;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_ptr;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  underflow;

    modport master (
        output r_inc,
        output w_ptr_sync,
        input  r_addr,
        input  r_ptr,
        input  empty,
        input  almost_empty,
        input  r_level,
        input  underflow
    );

    modport slave (
        input  r_inc,
        input  w_ptr_sync,
        output r_addr,
        output r_ptr,
        output empty,
        output almost_empty,
        output r_level,
        output underflow
    );
endinterface
`default_nettype wire

// File: rtl/rd_ptr_empty_gen.sv
`default_nettype none
// ============================================================================
// Module      : rd_ptr_empty_gen
// Description : Async-FIFO read-domain pointer and status generator. Holds
//               the binary read counter, drives the RAM read address and a
//               registered Gray read pointer, and derives registered EMPTY,
//               ALMOST_EMPTY, level and underflow from the synchronised
//               Gray write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_ptr_empty_gen #(
    parameter int ADDR_WIDTH = 3,
    parameter int AEMPTY_TH  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rd_ptr_empty_gen_if.slave  bus
);
    localparam int              c_PW        = ADDR_WIDTH + 1;
    localparam logic [c_PW-1:0] c_AEMPTY_TH = c_PW'(AEMPTY_TH);

    logic [c_PW-1:0] r_bin;
    logic [c_PW-1:0] r_ptr;
    logic [c_PW-1:0] r_level;
    logic            r_empty;
    logic            r_aempty;
    logic            r_underflow;

    logic            w_accept;
    logic [c_PW-1:0] w_bin_next;
    logic [c_PW-1:0] w_gray_next;
    logic [c_PW-1:0] w_wbin;
    logic [c_PW-1:0] w_level_next;

    // A read only counts when the registered EMPTY says a word is there,
    // so the pointer can never run past the writer.
    assign w_accept    = bus.r_inc & ~r_empty;
    assign w_bin_next  = r_bin + c_PW'(w_accept);
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // Gray-to-binary: bit i is the XOR of all Gray bits at and above i.
    // Written as a reduction per bit to avoid a self-referencing chain.
    generate
        for (genvar gi = 0; gi < c_PW; gi++) begin : g_gray2bin
            assign w_wbin[gi] = ^(bus.w_ptr_sync >> gi);
        end
    endgenerate

    // Modular difference; a legal writer keeps this within 0..2^ADDR_WIDTH.
    assign w_level_next = w_wbin - w_bin_next;

    // Pointer and status registers; status is computed from the post-read
    // pointer so reading the last word raises EMPTY on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin       <= '0;
            r_ptr       <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_bin       <= w_bin_next;
            r_ptr       <= w_gray_next;
            r_level     <= w_level_next;
            r_empty     <= (w_gray_next == bus.w_ptr_sync);
            r_aempty    <= (w_level_next <= c_AEMPTY_TH);
            r_underflow <= bus.r_inc & r_empty;
        end
    end

    assign bus.r_addr       = r_bin[ADDR_WIDTH-1:0];
    assign bus.r_ptr        = r_ptr;
    assign bus.r_level      = r_level;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_aempty;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rd_ptr_empty_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_ptr_empty_gen
// Description : Self-checking bench for rd_ptr_empty_gen. Two instances
//               (ADDR_WIDTH=3/AEMPTY_TH=1 and ADDR_WIDTH=5/AEMPTY_TH=4)
//               are compared each cycle against an occupancy-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_ptr_empty_gen;

    logic clk;
    logic rst_n;

    // Stimulus per instance: read request and total words ever written
    bit inc  [2];
    int wcnt [2];

    // Reference model: total accepted reads and registered status
    int m_rd    [2];
    int m_level [2];
    bit m_empty [2];
    bit m_aempty[2];
    bit m_uf    [2];

    int act_addr[2], act_ptr[2], act_level[2];
    int act_empty[2], act_aempty[2], act_uf[2];

    int total = 0;
    int bad   = 0;

    rd_ptr_empty_gen_if #(.ADDR_WIDTH(3)) bus3 ();
    rd_ptr_empty_gen_if #(.ADDR_WIDTH(5)) bus5 ();

    rd_ptr_empty_gen #(.ADDR_WIDTH(3), .AEMPTY_TH(1)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    rd_ptr_empty_gen #(.ADDR_WIDTH(5), .AEMPTY_TH(4)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic int depth(input int d);
        return (d == 0) ? 8 : 32;
    endfunction

    function automatic int thr(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    assign bus3.r_inc      = inc[0];
    assign bus5.r_inc      = inc[1];
    assign bus3.w_ptr_sync = 4'(gray(wcnt[0] % 16));
    assign bus5.w_ptr_sync = 6'(gray(wcnt[1] % 64));

    always_comb begin
        act_addr[0]   = int'(bus3.r_addr);
        act_ptr[0]    = int'(bus3.r_ptr);
        act_level[0]  = int'(bus3.r_level);
        act_empty[0]  = int'(bus3.empty);
        act_aempty[0] = int'(bus3.almost_empty);
        act_uf[0]     = int'(bus3.underflow);
        act_addr[1]   = int'(bus5.r_addr);
        act_ptr[1]    = int'(bus5.r_ptr);
        act_level[1]  = int'(bus5.r_level);
        act_empty[1]  = int'(bus5.empty);
        act_aempty[1] = int'(bus5.almost_empty);
        act_uf[1]     = int'(bus5.underflow);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d exp=%0d at %0t", name, d, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rd[d]     = 0;
            m_level[d]  = 0;
            m_empty[d]  = 1'b1;
            m_aempty[d] = 1'b1;
            m_uf[d]     = 1'b0;
        end
    endtask

    // One clock edge of the FIFO read side in terms of word counts
    task automatic model_edge(input int d);
        bit acc;
        acc        = inc[d] && !m_empty[d];
        m_uf[d]    = inc[d] && m_empty[d];
        m_rd[d]    = m_rd[d] + (acc ? 1 : 0);
        m_level[d] = wcnt[d] - m_rd[d];
        m_empty[d] = (m_level[d] == 0);
        m_aempty[d] = (m_level[d] <= thr(d));
    endtask

    task automatic check_all(input int d);
        chk("addr",   d, act_addr[d],   m_rd[d] % depth(d));
        chk("ptr",    d, act_ptr[d],    gray(m_rd[d] % (2 * depth(d))));
        chk("level",  d, act_level[d],  m_level[d]);
        chk("empty",  d, act_empty[d],  int'(m_empty[d]));
        chk("aempty", d, act_aempty[d], int'(m_aempty[d]));
        chk("uflow",  d, act_uf[d],     int'(m_uf[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        for (int d = 0; d < 2; d++) check_all(d);
    endtask

    typedef struct {
        bit inc;
        int w;
        int e_addr;
        int e_ptr;
        int e_level;
        bit e_empty;
        bit e_aempty;
        bit e_uf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int prev;
        int nb;

        tbl[0] = '{0, 8, 0,  0, 8, 0, 0, 0};
        tbl[1] = '{1, 8, 1,  1, 7, 0, 0, 0};
        tbl[2] = '{1, 8, 2,  3, 6, 0, 0, 0};
        tbl[3] = '{1, 8, 3,  2, 5, 0, 0, 0};
        tbl[4] = '{1, 8, 4,  6, 4, 0, 0, 0};
        tbl[5] = '{1, 8, 5,  7, 3, 0, 0, 0};
        tbl[6] = '{1, 8, 6,  5, 2, 0, 0, 0};
        tbl[7] = '{1, 8, 7,  4, 1, 0, 1, 0};
        tbl[8] = '{1, 8, 0, 12, 0, 1, 1, 0};
        tbl[9] = '{1, 8, 0, 12, 0, 1, 1, 1};

        rst_n = 1'b0;
        inc[0] = 0; inc[1] = 0;
        wcnt[0] = 0; wcnt[1] = 0;
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) check_all(d);
        rst_n = 1'b1;
        tick();

        // Fill/drain vectors on the 8-deep instance
        for (int i = 0; i < 10; i++) begin
            inc[0]  = tbl[i].inc;
            wcnt[0] = tbl[i].w;
            tick();
            chk("tbl_addr",   i, act_addr[0],   tbl[i].e_addr);
            chk("tbl_ptr",    i, act_ptr[0],    tbl[i].e_ptr);
            chk("tbl_level",  i, act_level[0],  tbl[i].e_level);
            chk("tbl_empty",  i, act_empty[0],  int'(tbl[i].e_empty));
            chk("tbl_aempty", i, act_aempty[0], int'(tbl[i].e_aempty));
            chk("tbl_uflow",  i, act_uf[0],     int'(tbl[i].e_uf));
        end

        // Underflow: repeated requests while empty pulse each cycle, no movement
        inc[0] = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("uf_pulse", 0, act_uf[0],    1);
            chk("uf_ptr",   0, act_ptr[0],   12);
            chk("uf_addr",  0, act_addr[0],  0);
            chk("uf_level", 0, act_level[0], 0);
        end
        inc[0] = 0;
        tick();
        chk("uf_clear", 0, act_uf[0], 0);

        // Simultaneous read and write keep the level constant
        wcnt[0] = 12;
        tick();
        chk("sim_pre_level", 0, act_level[0], 4);
        inc[0]  = 1;
        wcnt[0] = 13;
        tick();
        chk("sim_level", 0, act_level[0], 4);
        chk("sim_addr",  0, act_addr[0],  1);
        wcnt[0] = 13;
        for (int k = 0; k < 16 && !m_empty[0]; k++) tick();
        chk("drain_empty", 0, act_empty[0], 1);
        inc[0] = 0;

        // Wrap: bursts of three words, Gray pointer must step one bit at a time
        for (int r = 0; r < 40; r++) begin
            wcnt[0] = wcnt[0] + 3;
            tick();
            inc[0] = 1;
            for (int k = 0; k < 3; k++) begin
                prev = act_ptr[0];
                tick();
                nb = $countones(prev ^ act_ptr[0]);
                chk("gray_step", 0, nb, 1);
            end
            inc[0] = 0;
            chk("burst_empty", 0, act_empty[0], 1);
        end

        // Randomised traffic on both instances, writer never overfills
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                inc[d] = 1'($urandom_range(0, 1));
                if ((wcnt[d] - m_rd[d] < depth(d)) && ($urandom_range(0, 2) != 0))
                    wcnt[d] = wcnt[d] + 1;
            end
            tick();
        end

        // Asynchronous reset in the middle of a read stream
        inc[0] = 1; inc[1] = 1;
        wcnt[0] = m_rd[0] + 3; wcnt[1] = m_rd[1] + 3;
        tick();
        #3;
        rst_n = 1'b0;
        wcnt[0] = 0; wcnt[1] = 0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) check_all(d);
        chk("rst_empty", 0, act_empty[0], 1);
        #1;
        rst_n = 1'b1;
        inc[0] = 0; inc[1] = 0;
        tick();
        chk("post_rst_empty", 0, act_empty[0], 1);
        chk("post_rst_level", 0, act_level[0], 0);

        // Wide instance: three full 32-word fill/drain cycles (pointer wraps)
        for (int r = 0; r < 3; r++) begin
            inc[1] = 0;
            for (int k = 0; k < 32; k++) begin
                wcnt[1] = wcnt[1] + 1;
                tick();
            end
            chk("w5_full_level",  1, act_level[1],  32);
            chk("w5_full_aempty", 1, act_aempty[1], 0);
            inc[1] = 1;
            for (int k = 0; k < 32; k++) tick();
            chk("w5_drain_empty", 1, act_empty[1], 1);
        end
        inc[1] = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
